// File: rtl/program_loader_pkg.sv
// Shared types and constants for program_loader.
// Defining PROGRAM_LOADER_CHECKSUM_EN adds the CHECK state.
package program_loader_pkg;

    localparam int          BYTE_W    = 8;
    localparam logic [31:0] HALT_WORD = 32'hFFFF_FFFF;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RECV,
        ST_WRITE,
        ST_DONE,
        ST_ERROR
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        ,
        ST_CHECK
`endif
    } state_e;

endpackage

// File: rtl/program_loader_if.sv
// Link between the loader FSM (master) and its byte assembler (slave).
interface program_loader_if #(
    parameter int LEN = 32
);
    logic [program_loader_pkg::BYTE_W-1:0] byte_data;
    logic                                  byte_en;
    logic                                  clear;
    logic [LEN-1:0]                        word;
    logic                                  word_done;

    modport master (
        output byte_data, byte_en, clear,
        input  word, word_done
    );

    modport slave (
        input  byte_data, byte_en, clear,
        output word, word_done
    );
endinterface

// File: rtl/byte_assembler.sv
// Shifts accepted bytes into a big-endian word and strobes on the fourth byte.
module byte_assembler
    import program_loader_pkg::*;
#(
    parameter int LEN = 32
) (
    input logic            i_clk,
    input logic            i_rst,
    program_loader_if.slave bus
);

    logic [LEN-1:0] shift_q, shift_d;
    logic [1:0]     count_q, count_d;

    // NOTE: every always_comb output is given a default first so no latch is inferred.
    always_comb begin
        shift_d = shift_q;
        count_d = count_q;
        if (bus.clear) begin
            shift_d = '0;
            count_d = '0;
        end else if (bus.byte_en) begin
            shift_d = {shift_q[LEN-BYTE_W-1:0], bus.byte_data};
            count_d = count_q + 2'd1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            shift_q <= '0;
            count_q <= '0;
        end else begin
            shift_q <= shift_d;
            count_q <= count_d;
        end
    end

    assign bus.word      = {shift_q[LEN-BYTE_W-1:0], bus.byte_data};
    assign bus.word_done = bus.byte_en && (count_q == 2'd3);

endmodule

// File: rtl/program_loader.sv
// Loads big-endian program words from a byte stream into program memory.
// Optional PROGRAM_LOADER_CHECKSUM_EN: trailing XOR checksum byte after HALT.
module program_loader
    import program_loader_pkg::*;
#(
    parameter int LEN               = 32,
    parameter int RAM_DEPTH_PROGRAM = 2048,
    parameter int ADDR_W            = $clog2(RAM_DEPTH_PROGRAM)
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic [BYTE_W-1:0] i_rx_data,
    input  logic              i_rx_valid,
    output logic [ADDR_W-1:0] o_addr,
    output logic [LEN-1:0]    o_data,
    output logic              o_wea,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_error,
    output logic [ADDR_W:0]   o_word_count
);

    program_loader_if #(.LEN(LEN)) asm_bus ();

    state_e            state_q;
    logic [ADDR_W:0]   count_q;
    logic [ADDR_W-1:0] addr_q;
    logic [LEN-1:0]    data_q;
    logic              wea_q, busy_q, done_q, error_q;
    logic              session_start, accepting;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    logic [BYTE_W-1:0] csum_q;
`endif

    assign session_start     = i_start && (state_q inside {ST_IDLE, ST_DONE, ST_ERROR});
    assign accepting         = (state_q == ST_RECV) || (state_q == ST_WRITE);
    assign asm_bus.byte_data = i_rx_data;
    assign asm_bus.byte_en   = i_rx_valid && accepting;
    assign asm_bus.clear     = session_start;

    byte_assembler #(.LEN(LEN)) u_byte_assembler (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .bus   (asm_bus)
    );

    // NOTE: state is updated with non-blocking assignments only; reset is synchronous.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
            count_q <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            wea_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            error_q <= 1'b0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            csum_q  <= '0;
`endif
        end else begin
            wea_q <= 1'b0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            if (asm_bus.byte_en) csum_q <= csum_q ^ i_rx_data;
`endif
            case (state_q)
                ST_IDLE, ST_DONE, ST_ERROR: begin
                    if (i_start) begin
                        state_q <= ST_RECV;
                        count_q <= '0;
                        busy_q  <= 1'b1;
                        done_q  <= 1'b0;
                        error_q <= 1'b0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                        csum_q  <= '0;
`endif
                    end
                end
                ST_RECV: begin
                    if (asm_bus.word_done) begin
                        // A full memory means the completed word is dropped, not written.
                        if (count_q == (ADDR_W+1)'(RAM_DEPTH_PROGRAM)) begin
                            state_q <= ST_ERROR;
                            busy_q  <= 1'b0;
                            error_q <= 1'b1;
                        end else begin
                            state_q <= ST_WRITE;
                            wea_q   <= 1'b1;
                            addr_q  <= count_q[ADDR_W-1:0];
                            data_q  <= asm_bus.word;
                        end
                    end
                end
                ST_WRITE: begin
                    count_q <= count_q + (ADDR_W+1)'(1);
                    if (data_q == LEN'(HALT_WORD)) begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                        state_q <= ST_CHECK;
`else
                        state_q <= ST_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
`endif
                    end else begin
                        state_q <= ST_RECV;
                    end
                end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                ST_CHECK: begin
                    if (i_rx_valid) begin
                        busy_q <= 1'b0;
                        if (i_rx_data == csum_q) begin
                            state_q <= ST_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= ST_ERROR;
                            error_q <= 1'b1;
                        end
                    end
                end
`endif
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Reset suppresses a write even when it lands on the WRITE cycle.
    assign o_wea        = wea_q && !i_rst;
    assign o_addr       = addr_q;
    assign o_data       = data_q;
    assign o_busy       = busy_q;
    assign o_done       = done_q;
    assign o_error      = error_q;
    assign o_word_count = count_q;

endmodule

// File: doc/program_loader.md
PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 SHALL have parameter LEN, default 32, meaning instruction word width.
REQ-002 SHALL have parameter RAM_DEPTH_PROGRAM, default 2048, meaning the number of program memory words.
REQ-003 SHALL have parameter ADDR_W, default 11, meaning address width, equal to clog2(RAM_DEPTH_PROGRAM).
REQ-004 Ports:
  i_clk  in  1  the single clock; all logic on posedge.
  i_rst  in  1  reset; synchronous, active-high.
  i_start  in  1  pulse that begins a load session.
  i_rx_data  in  8  received byte.
  i_rx_valid  in  1  one-cycle strobe qualifying i_rx_data.
  o_addr  out  ADDR_W  program memory write address.
  o_data  out  LEN  program memory write data.
  o_wea  out  1  program memory write enable.
  o_busy  out  1  high in RECV or WRITE.
  o_done  out  1  load complete, halt word written.
  o_error  out  1  overflow or checksum failure.
  o_word_count  out  ADDR_W+1  number of words written this session.

Function
REQ-005 SHALL implement the FSM states IDLE, RECV, WRITE, DONE, ERROR.
REQ-006 IDLE -> RECV on i_start: address, byte and word counters cleared.
REQ-007 In RECV and WRITE, each i_rx_valid byte SHALL be shifted into a 32-bit assembly register, first byte landing in bits [31:24] (big-endian); no ready signal exists.
REQ-008 Acceptance of the 4th byte in cycle N SHALL move the FSM to WRITE in N+1, with o_wea=1 for exactly that one cycle, o_data = the assembled word and o_addr = the current address.
REQ-009 The assembled word SHALL be copied into a separate write register so that a byte arriving during WRITE starts the next word without corrupting o_data.
REQ-010 After WRITE: address and o_word_count SHALL increment by 1; the FSM returns to RECV, or goes to DONE if the written word is 32'hFFFF_FFFF (HALT).
REQ-011 The HALT word SHALL itself be written to memory.
REQ-012 If a word completes when the address equals RAM_DEPTH_PROGRAM, the FSM SHALL go to ERROR with no write, and o_wea SHALL stay 0.
REQ-013 DONE and ERROR SHALL be sticky and ignore bytes; i_start in either SHALL restart a session exactly as from IDLE.
REQ-014 i_start in RECV or WRITE SHALL be ignored.
REQ-015 o_wea SHALL be 0 in every state except WRITE; o_addr and o_data SHALL hold their last values otherwise.

Reset
REQ-016 On i_rst=1 at a posedge, regardless of state (including mid-word or WRITE): FSM=IDLE; all counters, o_addr, o_data and o_word_count = 0; o_wea, o_busy, o_done and o_error = 0; no write issued in that cycle; partially received bytes discarded.

Configuration
REQ-017 With PROGRAM_LOADER_CHECKSUM_EN defined: after the HALT write the FSM SHALL enter a CHECK state that awaits one extra byte. It goes to DONE if that byte equals the XOR of all payload bytes received this session, otherwise to ERROR. o_busy stays high in CHECK.
REQ-018 Without PROGRAM_LOADER_CHECKSUM_EN: no CHECK state and no XOR register; the FSM goes WRITE(HALT) -> DONE directly.

Structure
REQ-019 A shared package SHALL hold the FSM state encoding typedef, the HALT_WORD constant (32'hFFFF_FFFF) and the byte width constant (8).
REQ-020 A single sub-module byte_assembler (shift register plus 2-bit byte counter plus word-complete strobe) SHALL be used; the FSM and address logic stay in the top module.

Verification
REQ-021 Load 2 words: start, then bytes 20 01 00 05 FF FF FF FF -> o_wea at addr 0 with 0x20010005, then at addr 1 with 0xFFFFFFFF; o_done=1; o_word_count=2.
REQ-022 Back-to-back: a byte strobe in the WRITE cycle of word 0 -> word 1 assembles correctly; both writes occur with correct data.
REQ-023 Overflow: RAM_DEPTH_PROGRAM=4, send 5 non-HALT words -> 4 writes at addr 0..3, then o_error=1 with no 5th write.
REQ-024 Reset mid-word: send 2 bytes, assert i_rst, start again and load 0xAABBCCDD, HALT -> first write is 0xAABBCCDD at addr 0.
REQ-025 Checksum (macro defined): HALT-only program then byte 0x00 -> o_done=1; repeat with byte 0x01 -> o_error=1.
REQ-026 Restart: i_start while DONE -> new session writes from addr 0 with o_word_count reset.
